// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan controller: active-low
// cathode patterns {a,b,c,d,e,f,g}, converter FSM states and elaboration-time
// helper functions.
package seven_seg_pkg;

   localparam int unsigned SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;

   typedef enum logic [1:0] {
      CONV_IDLE  = 2'd0,
      CONV_SHIFT = 2'd1,
      CONV_DONE  = 2'd2
   } conv_state_t;

   // 10^n, used for the overflow threshold (n <= 8 fits comfortably in 64 bits)
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   // Ceiling log2; clog2(1) = 0
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // BCD nibble to cathode pattern; non-decimal nibbles are dark
   function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready intake.
// Ports:
//   clock_100Mhz  rising-edge clock
//   reset         synchronous, active-high; aborts any conversion in flight
//   value_in      unsigned binary value, taken on value_valid && value_ready
//   value_valid   value_in is offered
//   value_ready   converter idle (registered)
//   bcd           BCD shift register; holds the finished result while done_c is high
//   ovf           overflow flag of the value being converted
//   done_c        high for the single cycle in which bcd/ovf are final
module bin2bcd_serial
   import seven_seg_pkg::*;
#(
   parameter int unsigned BIN_WIDTH  = 16,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                    clock_100Mhz,
   input  logic                    reset,
   input  logic [BIN_WIDTH-1:0]    value_in,
   input  logic                    value_valid,
   output logic                    value_ready,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf,
   output logic                    done_c
);

   localparam int unsigned    BCD_W     = 4 * NUM_DIGITS;
   localparam int unsigned    CNT_W     = (clog2(BIN_WIDTH + 1) > 0) ? clog2(BIN_WIDTH + 1) : 1;
   localparam logic [63:0]    OVF_LIMIT = 64'(pow10(NUM_DIGITS));

   conv_state_t          state;
   logic [BIN_WIDTH-1:0] bin_sr;
   logic [CNT_W-1:0]     shift_cnt;
   logic [BCD_W-1:0]     bcd_adj_c;

   assign done_c = (state == CONV_DONE);

   // Add-3 correction applied to every nibble before each shift
   always_comb begin
      bcd_adj_c = bcd;
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
         if (bcd[d*4 +: 4] >= 4'd5) bcd_adj_c[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
   end

   // Converter FSM: IDLE -> SHIFT (BIN_WIDTH cycles) -> DONE (1 cycle) -> IDLE
   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         state       <= CONV_IDLE;
         value_ready <= 1'b1;
         bin_sr      <= '0;
         bcd         <= '0;
         ovf         <= 1'b0;
         shift_cnt   <= '0;
      end else begin
         case (state)
            CONV_IDLE: begin
               if (value_valid) begin
                  bin_sr      <= value_in;
                  bcd         <= '0;
                  ovf         <= (64'(value_in) >= OVF_LIMIT);
                  shift_cnt   <= '0;
                  value_ready <= 1'b0;
                  state       <= CONV_SHIFT;
               end
            end
            CONV_SHIFT: begin
               {bcd, bin_sr} <= {bcd_adj_c[BCD_W-2:0], bin_sr, 1'b0};
               shift_cnt     <= shift_cnt + CNT_W'(1);
               if (shift_cnt == CNT_W'(BIN_WIDTH - 1)) state <= CONV_DONE;
            end
            CONV_DONE: begin
               value_ready <= 1'b1;
               state       <= CONV_IDLE;
            end
            default: begin
               value_ready <= 1'b1;
               state       <= CONV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment driver: converts a binary value to decimal and
// scans the digits left to right with optional leading-zero blanking.
// Ports:
//   clock_100Mhz         rising-edge clock
//   reset                synchronous, active-high
//   value_in             unsigned binary value to display
//   value_valid          value_in is offered
//   value_ready          converter idle; transfer on valid && ready
//   blank_leading_zeros  1 blanks leading zero digits (live)
//   Anode_Activate       active-low one-cold digit enable, MSB = leftmost digit
//   LED_out              active-low cathodes {a,b,c,d,e,f,g}
//   overflow             displayed value was >= 10^NUM_DIGITS
module seven_segment_scan_controller
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned BIN_WIDTH    = 16,
   parameter int unsigned REFRESH_BITS = 18
) (
   input  logic                  clock_100Mhz,
   input  logic                  reset,
   input  logic [BIN_WIDTH-1:0]  value_in,
   input  logic                  value_valid,
   output logic                  value_ready,
   input  logic                  blank_leading_zeros,
   output logic [NUM_DIGITS-1:0] Anode_Activate,
   output logic [SEG_W-1:0]      LED_out,
   output logic                  overflow
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

   logic [BCD_W-1:0]        conv_bcd;
   logic                    conv_ovf;
   logic                    conv_done_c;
   logic [BCD_W-1:0]        display;
   logic [REFRESH_BITS-1:0] prescaler;
   logic [IDX_W-1:0]        digit_idx;
   logic [IDX_W-1:0]        digit_pos_c;
   logic [3:0]              digit_nib_c;
   logic                    zero_run_c;
   logic                    digit_lz_c;
   logic [NUM_DIGITS-1:0]   anode_c;
   logic [SEG_W-1:0]        led_c;

   bin2bcd_serial #(
      .BIN_WIDTH  (BIN_WIDTH),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .value_in     (value_in),
      .value_valid  (value_valid),
      .value_ready  (value_ready),
      .bcd          (conv_bcd),
      .ovf          (conv_ovf),
      .done_c       (conv_done_c)
   );

   // Select the scanned digit; digit_idx 0 is the leftmost (highest nibble).
   // zero_run_c tracks "this and all more-significant nibbles are zero".
   always_comb begin
      digit_pos_c = IDX_W'(NUM_DIGITS - 1) - digit_idx;
      digit_nib_c = 4'd0;
      digit_lz_c  = 1'b0;
      zero_run_c  = 1'b1;
      anode_c     = '1;
      for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
         zero_run_c = zero_run_c && (display[p*4 +: 4] == 4'd0);
         if (IDX_W'(p) == digit_pos_c) begin
            digit_nib_c = display[p*4 +: 4];
            digit_lz_c  = zero_run_c && (p != 0);
            anode_c[p]  = 1'b0;
         end
      end
   end

   // Segment pattern: overflow dash wins over blanking, blanking over decode
   always_comb begin
      led_c = seg_decode(digit_nib_c);
      if (overflow)                               led_c = SEG_DASH;
      else if (blank_leading_zeros && digit_lz_c) led_c = SEG_BLANK;
   end

   // Prescaler, scan index, display register and output registers
   always_ff @(posedge clock_100Mhz) begin
      if (reset) begin
         prescaler      <= '0;
         digit_idx      <= '0;
         display        <= '0;
         overflow       <= 1'b0;
         Anode_Activate <= '1;
         LED_out        <= SEG_BLANK;
      end else begin
         prescaler <= prescaler + REFRESH_BITS'(1);
         if (prescaler == '1) begin
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) digit_idx <= '0;
            else                                     digit_idx <= digit_idx + IDX_W'(1);
         end
         // Value and overflow flag change together so no slot mixes them
         if (conv_done_c) begin
            display  <= conv_bcd;
            overflow <= conv_ovf;
         end
         Anode_Activate <= anode_c;
         LED_out        <= led_c;
      end
   end

endmodule
